// File: rtl/vgpr_dep_tracker_pkg.sv
// ----------------------------------------------------------------------------
// vgpr_dep_tracker_pkg
// Shared issue-stage definitions for the VGPR dependency tracker:
//   - per-slot FSM state encoding (IDLE / WAIT / READY)
//   - default geometry used as parameter defaults by the tracker modules
// Configuration macro (consumed by vgpr_dep_tracker):
//   VGPR_DEP_TRACKER_ALLOC_BYPASS_EN - apply same-cycle retires to alloc_pending
// ----------------------------------------------------------------------------
package vgpr_dep_tracker_pkg;

    localparam int DEF_WF_SLOTS  = 40;
    localparam int DEF_WFID_W    = 6;
    localparam int DEF_NUM_OPS   = 6;
    localparam int DEF_MAX_WORDS = 4;
    localparam int DEF_ADDR_W    = 10;
    localparam int DEF_RET_PORTS = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } slot_state_t;

endpackage

// File: rtl/vgpr_dep_tracker_chk.sv
// ----------------------------------------------------------------------------
// vgpr_dep_tracker_chk
// Simulation checker for vgpr_dep_tracker: flags an issue of a slot that is
// still in WAIT (busy and not ready) unless a flush of that slot dominates.
// Ports: clk, rst, issue_valid/wfid, flush_valid/wfid, busy, ready (all in).
// ----------------------------------------------------------------------------
module vgpr_dep_tracker_chk
    import vgpr_dep_tracker_pkg::*;
#(
    parameter int WF_SLOTS = DEF_WF_SLOTS,
    parameter int WFID_W   = DEF_WFID_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [WFID_W-1:0]   issue_wfid,
    input  logic                flush_valid,
    input  logic [WFID_W-1:0]   flush_wfid,
    input  logic [WF_SLOTS-1:0] busy,
    input  logic [WF_SLOTS-1:0] ready
);

    logic illegal_issue_s;

    // Decode whether the issued slot is currently waiting on operands.
    always_comb begin
        illegal_issue_s = 1'b0;
        for (int s = 0; s < WF_SLOTS; s++) begin
            illegal_issue_s = illegal_issue_s
                            | (issue_valid
                               & (issue_wfid == WFID_W'(s))
                               & busy[s] & ~ready[s]
                               & ~(flush_valid & (flush_wfid == WFID_W'(s))));
        end
    end

    issue_from_wait_a: assert property (@(posedge clk) disable iff (rst) !illegal_issue_s)
        else $error("issue of a slot still in WAIT");

endmodule

// File: rtl/vgpr_dep_word_match.sv
// ----------------------------------------------------------------------------
// vgpr_dep_word_match
// Combinational match of one tracked operand against every retire port.
// Ports:
//   base         in  ADDR_W               base VGPR of the operand
//   pending      in  MAX_WORDS            words still outstanding
//   retire_valid in  RET_PORTS            per-port retire strobe
//   retire_addr  in  RET_PORTS*ADDR_W     base VGPR of each retiring write
//   retire_mask  in  RET_PORTS*MAX_WORDS  words written relative to retire_addr
//   clear        out MAX_WORDS            pending words satisfied this cycle
// ----------------------------------------------------------------------------
module vgpr_dep_word_match
    import vgpr_dep_tracker_pkg::*;
#(
    parameter int MAX_WORDS = DEF_MAX_WORDS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int RET_PORTS = DEF_RET_PORTS
) (
    input  logic [ADDR_W-1:0]              base,
    input  logic [MAX_WORDS-1:0]           pending,
    input  logic [RET_PORTS-1:0]           retire_valid,
    input  logic [RET_PORTS*ADDR_W-1:0]    retire_addr,
    input  logic [RET_PORTS*MAX_WORDS-1:0] retire_mask,
    output logic [MAX_WORDS-1:0]           clear
);

    // Word address one bit wider than ADDR_W so 1023+1 never aliases onto 0.
    function automatic logic [ADDR_W:0] word_addr(input logic [ADDR_W-1:0] b,
                                                  input int unsigned       off);
        return {1'b0, b} + (ADDR_W+1)'(off);
    endfunction

    // Each pending word clears if any valid port writes that exact address.
    always_comb begin
        clear = '0;
        for (int j = 0; j < MAX_WORDS; j++) begin
            for (int p = 0; p < RET_PORTS; p++) begin
                for (int k = 0; k < MAX_WORDS; k++) begin
                    clear[j] = clear[j]
                             | (pending[j]
                                & retire_valid[p]
                                & retire_mask[p*MAX_WORDS + k]
                                & (word_addr(retire_addr[p*ADDR_W +: ADDR_W], k)
                                   == word_addr(base, j)));
                end
            end
        end
    end

endmodule

// File: rtl/vgpr_dep_tracker.sv
// ----------------------------------------------------------------------------
// vgpr_dep_tracker
// Per-wavefront VGPR operand dependency tracker. One pending instruction per
// slot; every cycle all retire ports are matched against all tracked operand
// words, cleared words drop out, and a slot turns READY once nothing is left.
// Same-slot priority: flush > issue > alloc (alloc into a slot being freed is
// accepted; alloc into a slot that stays occupied is dropped with alloc_err).
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   alloc_valid/wfid/base/pending    load a new instruction into a slot
//   retire_valid/addr/mask           RET_PORTS multi-word VGPR write retires
//   issue_valid/wfid                 release a slot after issue
//   flush_valid/wfid                 discard a slot
//   ready  out WF_SLOTS              slot valid with no pending words
//   busy   out WF_SLOTS              slot valid (WAIT or READY)
//   alloc_err out 1                  one-cycle pulse on dropped alloc
// Macro: VGPR_DEP_TRACKER_ALLOC_BYPASS_EN - retires in the alloc cycle are
//   also applied to alloc_pending before it is stored.
// ----------------------------------------------------------------------------
module vgpr_dep_tracker
    import vgpr_dep_tracker_pkg::*;
#(
    parameter int WF_SLOTS  = DEF_WF_SLOTS,
    parameter int WFID_W    = DEF_WFID_W,
    parameter int NUM_OPS   = DEF_NUM_OPS,
    parameter int MAX_WORDS = DEF_MAX_WORDS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int RET_PORTS = DEF_RET_PORTS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           alloc_valid,
    input  logic [WFID_W-1:0]              alloc_wfid,
    input  logic [NUM_OPS*ADDR_W-1:0]      alloc_base,
    input  logic [NUM_OPS*MAX_WORDS-1:0]   alloc_pending,
    input  logic [RET_PORTS-1:0]           retire_valid,
    input  logic [RET_PORTS*ADDR_W-1:0]    retire_addr,
    input  logic [RET_PORTS*MAX_WORDS-1:0] retire_mask,
    input  logic                           issue_valid,
    input  logic [WFID_W-1:0]              issue_wfid,
    input  logic                           flush_valid,
    input  logic [WFID_W-1:0]              flush_wfid,
    output logic [WF_SLOTS-1:0]            ready,
    output logic [WF_SLOTS-1:0]            busy,
    output logic                           alloc_err
);

    localparam int PEND_W = NUM_OPS * MAX_WORDS;
    localparam int BASE_W = NUM_OPS * ADDR_W;

    slot_state_t       state_r     [WF_SLOTS];
    slot_state_t       state_nxt_s [WF_SLOTS];
    logic [PEND_W-1:0] pend_r      [WF_SLOTS];
    logic [PEND_W-1:0] pend_nxt_s  [WF_SLOTS];
    logic [PEND_W-1:0] clear_s     [WF_SLOTS];
    logic [BASE_W-1:0] base_r      [WF_SLOTS];
    logic [BASE_W-1:0] base_nxt_s  [WF_SLOTS];
    logic [PEND_W-1:0] alloc_eff_s;
    logic              alloc_err_nxt_s;
    logic [WF_SLOTS-1:0] ready_r;
    logic [WF_SLOTS-1:0] busy_r;
    logic                alloc_err_r;

    // Match every resident operand of every slot against the retire ports.
    for (genvar s = 0; s < WF_SLOTS; s++) begin : g_slot
        for (genvar o = 0; o < NUM_OPS; o++) begin : g_op
            vgpr_dep_word_match #(
                .MAX_WORDS (MAX_WORDS),
                .ADDR_W    (ADDR_W),
                .RET_PORTS (RET_PORTS)
            ) u_match (
                .base         (base_r[s][o*ADDR_W +: ADDR_W]),
                .pending      (pend_r[s][o*MAX_WORDS +: MAX_WORDS]),
                .retire_valid (retire_valid),
                .retire_addr  (retire_addr),
                .retire_mask  (retire_mask),
                .clear        (clear_s[s][o*MAX_WORDS +: MAX_WORDS])
            );
        end
    end

`ifdef VGPR_DEP_TRACKER_ALLOC_BYPASS_EN
    logic [PEND_W-1:0] byp_clear_s;

    // Same matcher applied to the incoming instruction so words retiring in
    // the alloc cycle are never stored as pending.
    for (genvar o = 0; o < NUM_OPS; o++) begin : g_byp
        vgpr_dep_word_match #(
            .MAX_WORDS (MAX_WORDS),
            .ADDR_W    (ADDR_W),
            .RET_PORTS (RET_PORTS)
        ) u_byp (
            .base         (alloc_base[o*ADDR_W +: ADDR_W]),
            .pending      (alloc_pending[o*MAX_WORDS +: MAX_WORDS]),
            .retire_valid (retire_valid),
            .retire_addr  (retire_addr),
            .retire_mask  (retire_mask),
            .clear        (byp_clear_s[o*MAX_WORDS +: MAX_WORDS])
        );
    end

    assign alloc_eff_s = alloc_pending & ~byp_clear_s;
`else
    assign alloc_eff_s = alloc_pending;
`endif

    // Next-state, pending and base per slot with flush > issue > alloc priority.
    always_comb begin
        alloc_err_nxt_s = 1'b0;
        for (int s = 0; s < WF_SLOTS; s++) begin
            logic freeing;
            logic free_after;
            logic alloc_hit;
            logic [PEND_W-1:0] pend_cur;

            freeing    = (flush_valid && (flush_wfid == WFID_W'(s)))
                      || (issue_valid && (issue_wfid == WFID_W'(s)));
            free_after = (state_r[s] == ST_IDLE) || freeing;
            alloc_hit  = alloc_valid && (alloc_wfid == WFID_W'(s));
            pend_cur   = pend_r[s] & ~clear_s[s];

            state_nxt_s[s] = state_r[s];
            pend_nxt_s[s]  = pend_cur;
            base_nxt_s[s]  = base_r[s];

            if (alloc_hit && free_after) begin
                pend_nxt_s[s]  = alloc_eff_s;
                base_nxt_s[s]  = alloc_base;
                state_nxt_s[s] = (|alloc_eff_s) ? ST_WAIT : ST_READY;
            end else if (freeing) begin
                state_nxt_s[s] = ST_IDLE;
                pend_nxt_s[s]  = '0;
            end else begin
                case (state_r[s])
                    ST_WAIT:  state_nxt_s[s] = (|pend_cur) ? ST_WAIT : ST_READY;
                    ST_READY: state_nxt_s[s] = ST_READY;
                    ST_IDLE:  state_nxt_s[s] = ST_IDLE;
                    default:  state_nxt_s[s] = ST_IDLE;
                endcase
            end

            alloc_err_nxt_s = alloc_err_nxt_s | (alloc_hit & ~free_after);
        end
    end

    // Slot state, operand registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < WF_SLOTS; s++) begin
                state_r[s] <= ST_IDLE;
                pend_r[s]  <= '0;
                base_r[s]  <= '0;
            end
            ready_r     <= '0;
            busy_r      <= '0;
            alloc_err_r <= 1'b0;
        end else begin
            for (int s = 0; s < WF_SLOTS; s++) begin
                state_r[s] <= state_nxt_s[s];
                pend_r[s]  <= pend_nxt_s[s];
                base_r[s]  <= base_nxt_s[s];
                ready_r[s] <= (state_nxt_s[s] == ST_READY);
                busy_r[s]  <= (state_nxt_s[s] != ST_IDLE);
            end
            alloc_err_r <= alloc_err_nxt_s;
        end
    end

    assign ready     = ready_r;
    assign busy      = busy_r;
    assign alloc_err = alloc_err_r;

endmodule

// File: tb/tb_vgpr_dep_tracker.sv
// ----------------------------------------------------------------------------
// tb_vgpr_dep_tracker
// Scoreboarded bench for vgpr_dep_tracker: each step drives one cycle of
// strobes, pushes the expected busy/ready/alloc_err for the next cycle, and
// pops/compares after the clock edge.
// ----------------------------------------------------------------------------
module tb_vgpr_dep_tracker;

    localparam int WF_SLOTS  = 40;
    localparam int WFID_W    = 6;
    localparam int NUM_OPS   = 6;
    localparam int MAX_WORDS = 4;
    localparam int ADDR_W    = 10;
    localparam int RET_PORTS = 2;

    logic                           clk = 1'b0;
    logic                           rst;
    logic                           alloc_valid;
    logic [WFID_W-1:0]              alloc_wfid;
    logic [NUM_OPS*ADDR_W-1:0]      alloc_base;
    logic [NUM_OPS*MAX_WORDS-1:0]   alloc_pending;
    logic [RET_PORTS-1:0]           retire_valid;
    logic [RET_PORTS*ADDR_W-1:0]    retire_addr;
    logic [RET_PORTS*MAX_WORDS-1:0] retire_mask;
    logic                           issue_valid;
    logic [WFID_W-1:0]              issue_wfid;
    logic                           flush_valid;
    logic [WFID_W-1:0]              flush_wfid;
    logic [WF_SLOTS-1:0]            ready;
    logic [WF_SLOTS-1:0]            busy;
    logic                           alloc_err;

    vgpr_dep_tracker #(
        .WF_SLOTS (WF_SLOTS), .WFID_W (WFID_W), .NUM_OPS (NUM_OPS),
        .MAX_WORDS (MAX_WORDS), .ADDR_W (ADDR_W), .RET_PORTS (RET_PORTS)
    ) dut (
        .clk (clk), .rst (rst),
        .alloc_valid (alloc_valid), .alloc_wfid (alloc_wfid),
        .alloc_base (alloc_base), .alloc_pending (alloc_pending),
        .retire_valid (retire_valid), .retire_addr (retire_addr),
        .retire_mask (retire_mask),
        .issue_valid (issue_valid), .issue_wfid (issue_wfid),
        .flush_valid (flush_valid), .flush_wfid (flush_wfid),
        .ready (ready), .busy (busy), .alloc_err (alloc_err)
    );

    vgpr_dep_tracker_chk #(.WF_SLOTS (WF_SLOTS), .WFID_W (WFID_W)) u_chk (
        .clk (clk), .rst (rst),
        .issue_valid (issue_valid), .issue_wfid (issue_wfid),
        .flush_valid (flush_valid), .flush_wfid (flush_wfid),
        .busy (busy), .ready (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        string               tag;
        logic [WF_SLOTS-1:0] busy;
        logic [WF_SLOTS-1:0] ready;
        logic                err;
    } exp_t;

    exp_t                sb_q[$];
    int                  vec_cnt = 0;
    int                  miscmp_cnt = 0;
    logic [WF_SLOTS-1:0] m_busy;
    logic [WF_SLOTS-1:0] m_ready;
    logic                m_err;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vec_cnt++;
        if (obs !== exp_v) begin
            miscmp_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_inputs();
        alloc_valid   = 1'b0;
        alloc_wfid    = '0;
        alloc_base    = '0;
        alloc_pending = '0;
        retire_valid  = '0;
        retire_addr   = '0;
        retire_mask   = '0;
        issue_valid   = 1'b0;
        issue_wfid    = '0;
        flush_valid   = 1'b0;
        flush_wfid    = '0;
    endtask

    task automatic alloc(input int slot);
        alloc_valid = 1'b1;
        alloc_wfid  = WFID_W'(slot);
    endtask

    task automatic set_op(input int op, input int base, input logic [3:0] pend);
        alloc_base[op*ADDR_W +: ADDR_W]          = ADDR_W'(base);
        alloc_pending[op*MAX_WORDS +: MAX_WORDS] = pend;
    endtask

    task automatic set_ret(input int p, input int addr, input logic [3:0] mask);
        retire_valid[p]                        = 1'b1;
        retire_addr[p*ADDR_W +: ADDR_W]        = ADDR_W'(addr);
        retire_mask[p*MAX_WORDS +: MAX_WORDS]  = mask;
    endtask

    task automatic issue(input int slot);
        issue_valid = 1'b1;
        issue_wfid  = WFID_W'(slot);
    endtask

    task automatic flush(input int slot);
        flush_valid = 1'b1;
        flush_wfid  = WFID_W'(slot);
    endtask

    // Push expectation for the next cycle, clock, then drain the scoreboard.
    task automatic step(input string tag);
        exp_t e;
        sb_q.push_back('{tag, m_busy, m_ready, m_err});
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val({e.tag, "_busy"},  64'(busy),      64'(e.busy));
            check_val({e.tag, "_ready"}, 64'(ready),     64'(e.ready));
            check_val({e.tag, "_err"},   64'(alloc_err), 64'(e.err));
        end
        clear_inputs();
        m_err = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_busy  = '0;
        m_ready = '0;
        m_err   = 1'b0;
        clear_inputs();
        rst = 1'b1;
        step("reset0");
        step("reset1");
        rst = 1'b0;

        // Two retires complete a 4-word operand from the top half first.
        alloc(3); set_op(0, 8, 4'b1111); m_busy[3] = 1'b1;
        step("a_alloc");
        set_ret(0, 10, 4'b0011);
        step("a_ret_hi");
        set_ret(0, 8, 4'b0011); m_ready[3] = 1'b1;
        step("a_ret_lo");
        issue(3); m_busy[3] = 1'b0; m_ready[3] = 1'b0;
        step("a_issue");

        // Both ports together cover words 8..10.
        alloc(4); set_op(2, 8, 4'b0111); m_busy[4] = 1'b1;
        step("b_alloc");
        set_ret(0, 6, 4'b1100); set_ret(1, 10, 4'b0001); m_ready[4] = 1'b1;
        step("b_two_ports");

        // 1023+1 must not alias onto address 0.
        alloc(6); set_op(1, 0, 4'b0001); m_busy[6] = 1'b1;
        step("c_alloc");
        set_ret(0, 1023, 4'b0011);
        step("c_wrap");
        set_ret(1, 0, 4'b0001); m_ready[6] = 1'b1;
        step("c_hit");

        // Alloc to an occupied slot is dropped; old operand still governs.
        alloc(5); set_op(0, 100, 4'b0001); m_busy[5] = 1'b1;
        step("d_alloc");
        alloc(5); set_op(0, 200, 4'b0010); m_err = 1'b1;
        step("d_busy_err");
        step("d_err_clr");
        set_ret(0, 100, 4'b0001); m_ready[5] = 1'b1;
        step("d_old_kept");
        issue(5); alloc(5); set_op(0, 300, 4'b0001); m_ready[5] = 1'b0;
        step("d_issue_alloc");
        set_ret(0, 300, 4'b0001); m_ready[5] = 1'b1;
        step("d_new_hit");
        issue(5); m_busy[5] = 1'b0; m_ready[5] = 1'b0;
        step("d_issue");

        // Flush beats a completing retire.
        alloc(7); set_op(3, 50, 4'b0011); m_busy[7] = 1'b1;
        step("e_alloc");
        flush(7); set_ret(0, 50, 4'b0011); m_busy[7] = 1'b0;
        step("e_flush_ret");

        // Retire in the alloc cycle only counts with the bypass build.
        alloc(9); set_op(0, 20, 4'b0001); set_ret(0, 20, 4'b0001); m_busy[9] = 1'b1;
`ifdef VGPR_DEP_TRACKER_ALLOC_BYPASS_EN
        m_ready[9] = 1'b1;
`endif
        step("f_alloc_ret");
        step("f_hold");
        flush(9); m_busy[9] = 1'b0; m_ready[9] = 1'b0;
        step("f_flush");

        // Two operands; both ports hit the same last word in one cycle.
        alloc(10); set_op(0, 40, 4'b0001); set_op(5, 60, 4'b1000); m_busy[10] = 1'b1;
        step("g_alloc");
        set_ret(1, 40, 4'b0001);
        step("g_first_op");
        set_ret(0, 63, 4'b0001); set_ret(1, 61, 4'b0100); m_ready[10] = 1'b1;
        step("g_dup_hit");

        // Empty pending mask goes straight to READY in the highest slot.
        alloc(39); m_busy[39] = 1'b1; m_ready[39] = 1'b1;
        step("h_direct_ready");
        flush(6); issue(4);
        m_busy[6] = 1'b0; m_ready[6] = 1'b0; m_busy[4] = 1'b0; m_ready[4] = 1'b0;
        step("h_flush_issue");

        // Reset mid-operation drops everything, retires in that cycle ignored.
        alloc(12); set_op(0, 500, 4'b0011); m_busy[12] = 1'b1;
        step("i_alloc");
        rst = 1'b1; set_ret(0, 500, 4'b0011);
        m_busy = '0; m_ready = '0;
        step("i_reset");
        rst = 1'b0;
        step("i_after");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule

// File: doc/vgpr_dep_tracker.md
# vgpr_dep_tracker

Per-wavefront VGPR operand dependency tracker for the issue stage. It is the parametrised successor of the combinational single-retire VGPR operand comparator. It holds one pending instruction per wavefront slot and compares every retiring multi-word VGPR write against all tracked operands each cycle. It clears per-word pending bits and raises a per-slot ready flag once every operand word is available. Operand width (up to MAX_WORDS), operand count and retire-port count are all generalised.

## Interface
- WF_SLOTS, 40, number of wavefront slots / entries
- WFID_W, 6, wavefront id width (ceil log2 WF_SLOTS)
- NUM_OPS, 6, tracked operands per entry (sources plus destinations)
- MAX_WORDS, 4, max words per operand (power of two)
- ADDR_W, 10, VGPR address width (`VGPR_ADDR_LENGTH)
- RET_PORTS, 2, independent retire ports per cycle
- clk  in  1  clock; one clock for the whole block
- rst  in  1  synchronous, active-high reset
- alloc_valid  in  1  load a new instruction into slot alloc_wfid
- alloc_wfid  in  WFID_W  target slot
- alloc_base  in  NUM_OPS*ADDR_W  base VGPR per operand
- alloc_pending  in  NUM_OPS*MAX_WORDS  words still outstanding at allocation; zero bits for unused operands/words
- retire_valid  in  RET_PORTS  per-port retire strobe
- retire_addr  in  RET_PORTS*ADDR_W  base VGPR of the retiring write
- retire_mask  in  RET_PORTS*MAX_WORDS  words written, relative to retire_addr
- issue_valid  in  1  release slot issue_wfid (instruction issued)
- issue_wfid  in  WFID_W  slot to release
- flush_valid  in  1  discard slot flush_wfid (wavefront halt/branch)
- flush_wfid  in  WFID_W  slot to discard
- ready  out  WF_SLOTS  slot valid with no pending words
- busy  out  WF_SLOTS  slot valid (WAIT or READY)
- alloc_err  out  1  pulse: alloc to a non-IDLE slot (dropped)

## Operation
- Per-slot FSM with states IDLE, WAIT and READY.
  - IDLE -> WAIT on alloc when the effective pending mask is nonzero.
  - IDLE -> READY on alloc when the effective pending mask is zero.
  - WAIT -> READY when all pending bits clear.
  - READY/WAIT -> IDLE on issue or flush.
- Issue from WAIT is illegal. It is still honoured (slot cleared) and asserted in simulation.
- Word clear rule: pending[op][j] clears if any port p has retire_valid[p] and some k with retire_mask[p][k] such that retire_addr[p]+k == base[op]+j.
- Sums are computed at ADDR_W+1 bits, so there is no wrap-around; address 1023+1 does not match 0.
- Multiple ports hitting the same word in one cycle is legal; the bit is cleared once.
- Priority on the same slot in one cycle: flush > issue > alloc.
  - Alloc coincident with issue/flush of the same slot is accepted (the slot is being freed); the new contents win.
  - Alloc to a slot that stays WAIT/READY is dropped and alloc_err pulses.
- Retires apply to all resident slots every cycle.
- Reset: all slots IDLE, all pending bits 0, ready=0, busy=0, alloc_err=0.

## Timing
- Alloc at cycle t: the entry is visible (busy=1) at t+1.
- Retire at cycle t clears bits at t+1. If those were the last bits, ready=1 at t+1 (registered state; ready is decoded from state).
- Issue/flush at t: busy=ready=0 at t+1.
- alloc_err is registered and high exactly one cycle (t+1).
- No backpressure: every input is a single-cycle strobe, consumed unconditionally.
- rst mid-operation discards all entries at the next edge; retires in the reset cycle are ignored.

## Configuration
- VGPR_DEP_TRACKER_ALLOC_BYPASS_EN defined: retires in the allocation cycle are also applied to the incoming alloc_pending before it is stored. An alloc with a same-cycle retire covering all words goes IDLE -> READY directly.
- Undefined: alloc_pending is stored as given. The producer of alloc_pending must already exclude words retiring in that cycle.

## Structure
- Shared issue package/defines file holds the FSM state encoding (IDLE=2'd0, WAIT=2'd1, READY=2'd2) and the default widths.
- One sub-module, vgpr_dep_word_match: combinational match for one operand against all retire ports. Inputs are base, pending, retire_valid, retire_addr and retire_mask; output is a MAX_WORDS clear mask. It is instantiated WF_SLOTS*NUM_OPS times via generate.
- The top module holds the state, pending registers and priority logic.

## Test plan
- Reset, then alloc slot 3: base[0]=8, pending[0]=4'b1111. Retire addr 10, mask 4'b0011, then retire addr 8, mask 4'b0011 -> busy[3]=1 throughout; ready[3]=0 after the first retire and 1 the cycle after the second.
- Two ports in the same cycle (addr 6 mask 4'b1100, addr 10 mask 4'b0001) against operand base 8, pending 4'b0111 -> ready next cycle.
- Wrap: operand base 0, pending 4'b0001; retire addr 1023, mask 4'b0011 -> no clear, ready stays 0.
- Alloc to busy slot 5 -> alloc_err high one cycle, slot contents unchanged. Issue and alloc to slot 5 in the same cycle -> new entry loaded, no alloc_err.
- Flush slot 7 in WAIT with a retire that would complete it in the same cycle -> busy[7]=ready[7]=0 next cycle.
- With ALLOC_BYPASS_EN: alloc pending 4'b0001 base 20 plus same-cycle retire addr 20 mask 1 -> ready=1 at t+1. Without the macro -> WAIT, ready stays 0.
